arkanoid_iir_sched: RTL and testbench

// - Time-multiplexed scheduler for first-order IIR low-pass sections on the sound path.
// - Generates the sample tick from clk.
// - Sequences one shared 18x18 multiply-accumulate across CHANNELS audio channels.
// - Holds a per-channel coefficient register file, with shadowed config writes.
// - Sits between the PSG channel outputs and the audio mixer.

---
 rtl/arkanoid_iir_sched_if.sv | 22 ++
 rtl/arkanoid_iir_sched.sv | 175 +++++++++++++++++
 tb/tb_arkanoid_iir_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arkanoid_iir_sched_if.sv
// Bus bundle for the IIR scheduler: sample in/out buses plus the coefficient write port.
interface arkanoid_iir_sched_if #(
  parameter int unsigned CHANNELS = 3
);
  logic [16*CHANNELS-1:0] in_bus;
  logic                   cfg_we;
  logic [4:0]             cfg_addr;
  logic [17:0]            cfg_data;
  logic [16*CHANNELS-1:0] out_bus;
  logic                   out_valid;
  logic                   busy;

  modport master (
    output in_bus, cfg_we, cfg_addr, cfg_data,
    input  out_bus, out_valid, busy
  );

  modport slave (
    input  in_bus, cfg_we, cfg_addr, cfg_data,
    output out_bus, out_valid, busy
  );
endinterface

// File: rtl/arkanoid_iir_sched.sv
// Time-multiplexed first-order IIR low-pass scheduler: one shared 18x18 MAC
// walks all channels once per sample tick, with shadowed coefficient writes.
module arkanoid_iir_sched #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DIV      = 64
) (
  input logic                clk,
  input logic                reset,
  arkanoid_iir_sched_if.slave bus
);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic signed [17:0] B_DEF  = 18'sd7278;
  localparam logic signed [17:0] A2_DEF = -18'sd18211;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, WB, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CHW-1:0]         chan_q, chan_d;
  logic signed [37:0]     acc_q, acc_d;
  logic signed [15:0]     x_lat_q [CHANNELS], x_lat_d [CHANNELS];
  logic signed [15:0]     x1_q    [CHANNELS], x1_d    [CHANNELS];
  logic signed [15:0]     y1_q    [CHANNELS], y1_d    [CHANNELS];
  logic signed [15:0]     y_res_q [CHANNELS], y_res_d [CHANNELS];
  logic signed [17:0]     coef_sh_q  [CHANNELS][3], coef_sh_d  [CHANNELS][3];
  logic signed [17:0]     coef_act_q [CHANNELS][3], coef_act_d [CHANNELS][3];
  logic [16*CHANNELS-1:0] out_bus_q, out_bus_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic                   tick_c;
  logic [2:0]             cfg_chan_c;
  logic [1:0]             cfg_sel_c;
  logic                   cfg_ok_c;
  logic signed [15:0]     x_sel_c, x1_sel_c, y1_sel_c, y_sat_c;
  logic signed [17:0]     b1_sel_c, b2_sel_c, a2_sel_c, mul_a_c, mul_b_c;
  logic signed [35:0]     prod_c;
  logic signed [37:0]     prod_ext_c, acc_shift_c;

  assign tick_c     = (cnt_q == CW'(DIV - 1));
  assign cfg_chan_c = bus.cfg_addr[4:2];
  assign cfg_sel_c  = bus.cfg_addr[1:0];
  assign cfg_ok_c   = bus.cfg_we && (cfg_sel_c != 2'd3) && (32'(cfg_chan_c) < CHANNELS);

  assign bus.out_bus   = out_bus_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      chan_q      <= '0;
      acc_q       <= '0;
      out_bus_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        x_lat_q[c]       <= '0;
        x1_q[c]          <= '0;
        y1_q[c]          <= '0;
        y_res_q[c]       <= '0;
        coef_sh_q[c][0]  <= B_DEF;
        coef_sh_q[c][1]  <= B_DEF;
        coef_sh_q[c][2]  <= A2_DEF;
        coef_act_q[c][0] <= B_DEF;
        coef_act_q[c][1] <= B_DEF;
        coef_act_q[c][2] <= A2_DEF;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      acc_q       <= acc_d;
      out_bus_q   <= out_bus_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      x_lat_q     <= x_lat_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      y_res_q     <= y_res_d;
      coef_sh_q   <= coef_sh_d;
      coef_act_q  <= coef_act_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    acc_d       = acc_q;
    x_lat_d     = x_lat_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    y_res_d     = y_res_q;
    coef_sh_d   = coef_sh_q;
    coef_act_d  = coef_act_q;
    out_bus_d   = out_bus_q;
    out_valid_d = 1'b0;
    cnt_d       = tick_c ? '0 : cnt_q + CW'(1);
    x_sel_c     = '0;
    x1_sel_c    = '0;
    y1_sel_c    = '0;
    b1_sel_c    = '0;
    b2_sel_c    = '0;
    a2_sel_c    = '0;

    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned s = 0; s < 3; s++) begin
        if (cfg_ok_c && cfg_chan_c == 3'(c) && cfg_sel_c == 2'(s)) coef_sh_d[c][s] = bus.cfg_data;
      end
      if (chan_q == CHW'(c)) begin
        x_sel_c  = x_lat_q[c];
        x1_sel_c = x1_q[c];
        y1_sel_c = y1_q[c];
        b1_sel_c = coef_act_q[c][0];
        b2_sel_c = coef_act_q[c][1];
        a2_sel_c = coef_act_q[c][2];
      end
    end

    // Shared multiplier: operand pair chosen by the MAC phase.
    mul_a_c = b1_sel_c;
    mul_b_c = {{2{x_sel_c[15]}}, x_sel_c};
    if (state_q == MAC1) begin
      mul_a_c = b2_sel_c;
      mul_b_c = {{2{x1_sel_c[15]}}, x1_sel_c};
    end else if (state_q == MAC2) begin
      mul_a_c = a2_sel_c;
      mul_b_c = {{2{y1_sel_c[15]}}, y1_sel_c};
    end
    prod_c      = mul_a_c * mul_b_c;
    prod_ext_c  = {{2{prod_c[35]}}, prod_c};
    acc_shift_c = acc_q >>> 15;
    if (acc_shift_c > 38'sd32767)       y_sat_c = 16'sd32767;
    else if (acc_shift_c < -38'sd32768) y_sat_c = -16'sd32768;
    else                                y_sat_c = acc_shift_c[15:0];

    case (state_q)
      IDLE: if (tick_c) begin
        for (int unsigned c = 0; c < CHANNELS; c++) x_lat_d[c] = bus.in_bus[16*c +: 16];
        coef_act_d = coef_sh_d;
        chan_d     = '0;
        state_d    = MAC0;
      end
      MAC0: begin acc_d = prod_ext_c;         state_d = MAC1; end
      MAC1: begin acc_d = acc_q + prod_ext_c; state_d = MAC2; end
      MAC2: begin acc_d = acc_q - prod_ext_c; state_d = WB;   end
      WB: begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (chan_q == CHW'(c)) begin
            y_res_d[c] = y_sat_c;
            x1_d[c]    = x_lat_q[c];
            y1_d[c]    = y_sat_c;
          end
        end
        // Output register loads on entry to DONE so the bus is valid with the pulse.
        if (chan_q == CHW'(CHANNELS - 1)) begin
          for (int unsigned c = 0; c < CHANNELS; c++) out_bus_d[16*c +: 16] = y_res_d[c];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          chan_d  = chan_q + CHW'(1);
          state_d = MAC0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  tick_while_busy: assert property (@(posedge clk) disable iff (!reset) !(tick_c && state_q != IDLE));
endmodule

// File: tb/tb_arkanoid_iir_sched.sv
// Directed self-checking bench for arkanoid_iir_sched (CHANNELS=3, DIV=64).
module tb_arkanoid_iir_sched;
  localparam int unsigned CH  = 3;
  localparam int unsigned DIV = 64;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arkanoid_iir_sched_if #(.CHANNELS(CH)) bus();

  arkanoid_iir_sched #(.CHANNELS(CH), .DIV(DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic int outch(input int k);
    logic signed [15:0] v;
    v = bus.out_bus[16*k +: 16];
    return int'(v);
  endfunction

  task automatic set_in(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c);
    bus.in_bus = {c, b, a};
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int sel, input logic signed [17:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = {3'(ch), 2'(sel)};
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_valid(output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_busy_rise(output int c, output bit timeout);
    bit seen_low = 1'b0;
    timeout = 1'b1;
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) seen_low = 1'b1;
      else if (seen_low && bus.busy === 1'b1) begin
        c = cyc;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    bit to;
    int r;
    reset        = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    set_in(16'sd0, 16'sd0, 16'sd0);
    repeat (2) @(negedge clk);
    checks++; if (bus.out_bus !== '0) begin errors++; $display("FAIL reset_out_bus: got %h expected 0", bus.out_bus); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b1;
    r = cyc;
    wait_valid(to);
    checks++; if (to || (cyc - r) != 76) begin errors++; $display("FAIL reset_first_valid_latency: got %0d expected 76 (timeout=%0b)", cyc - r, to); end
  endtask

  task automatic test_timing();
    bit to;
    int c, prev_c, n, nv, vc, r;
    set_in(16'sd0, 16'sd0, 16'sd0);
    do_reset();
    r = cyc;
    prev_c = 0;
    for (int k = 0; k < 3; k++) begin
      wait_busy_rise(c, to);
      checks++; if (to) begin errors++; $display("FAIL timing_busy_rise_timeout: got timeout expected busy edge"); end
      if (k == 0) begin
        checks++; if (c - r != 64) begin errors++; $display("FAIL timing_first_busy: got %0d expected 64", c - r); end
      end else begin
        checks++; if (c - prev_c != 64) begin errors++; $display("FAIL timing_period: got %0d expected 64", c - prev_c); end
      end
      n = 0; nv = 0; vc = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.busy === 1'b1) n++;
        if (bus.out_valid === 1'b1) begin nv++; vc = cyc; end
        @(negedge clk);
      end
      checks++; if (n != 13) begin errors++; $display("FAIL timing_busy_len: got %0d expected 13", n); end
      checks++; if (nv != 1) begin errors++; $display("FAIL timing_valid_count: got %0d expected 1", nv); end
      checks++; if (vc - c != 12) begin errors++; $display("FAIL timing_valid_offset: got %0d expected 12", vc - c); end
      prev_c = c;
    end
  endtask

  task automatic test_impulse();
    bit to;
    int exp0 [4] = '{3639, 5661, 3146, 1748};
    set_in(16'sd16384, 16'sd0, 16'sd0);
    do_reset();
    for (int t = 0; t < 4; t++) begin
      wait_valid(to);
      checks++; if (to || outch(0) != exp0[t]) begin errors++; $display("FAIL impulse_ch0_t%0d: got %0d expected %0d (timeout=%0b)", t, outch(0), exp0[t], to); end
      checks++; if (outch(1) != 0 || outch(2) != 0) begin errors++; $display("FAIL impulse_ch12_t%0d: got %0d/%0d expected 0/0", t, outch(1), outch(2)); end
      set_in(16'sd0, 16'sd0, 16'sd0);
      if (t == 1) begin
        // in_bus wiggles between ticks must not leak into the result
        for (int i = 0; i < 20; i++) begin
          bus.in_bus = 48'($urandom) ^ {16'($urandom), 32'd0};
          @(negedge clk);
        end
        set_in(16'sd0, 16'sd0, 16'sd0);
        checks++; if (outch(0) != 5661 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL impulse_hold: got %0d valid=%b expected 5661 valid=0", outch(0), bus.out_valid); end
      end
    end
  endtask

  task automatic test_saturation();
    bit to;
    int expv [4] = '{32766, 32767, -1, -32768};
    set_in(16'sd32767, 16'sd0, 16'sd0);
    do_reset();
    cfg_write(0, 0, 18'sd32767);
    cfg_write(0, 1, 18'sd32767);
    cfg_write(0, 2, 18'sd0);
    for (int t = 0; t < 4; t++) begin
      wait_valid(to);
      checks++; if (to || outch(0) != expv[t]) begin errors++; $display("FAIL saturation_t%0d: got %0d expected %0d (timeout=%0b)", t, outch(0), expv[t], to); end
      if (t == 1) set_in(-16'sd32768, 16'sd0, 16'sd0);
    end
  endtask

  task automatic test_shadow();
    bit to;
    int c;
    set_in(16'sd0, 16'sd16384, 16'sd0);
    do_reset();
    wait_busy_rise(c, to);
    wait_until(c + 4);
    checks++; if (to || bus.busy !== 1'b1) begin errors++; $display("FAIL shadow_busy_at_write: got %b expected 1 (timeout=%0b)", bus.busy, to); end
    cfg_write(1, 0, 18'sd0);
    wait_valid(to);
    checks++; if (to || outch(1) != 3639) begin errors++; $display("FAIL shadow_current: got %0d expected 3639 (timeout=%0b)", outch(1), to); end
    wait_valid(to);
    checks++; if (to || outch(1) != 5661) begin errors++; $display("FAIL shadow_next: got %0d expected 5661 (timeout=%0b)", outch(1), to); end
  endtask

  task automatic test_cfg_edge();
    bit to;
    int c;
    set_in(16'sd0, 16'sd0, 16'sd0);
    do_reset();
    wait_busy_rise(c, to);
    wait_until(c + 20);
    cfg_write(0, 3, 18'sd0);
    cfg_write(3, 0, 18'sd0);
    cfg_write(7, 2, 18'sd0);
    set_in(16'sd16384, 16'sd0, 16'sd16384);
    wait_until(c + 63);
    cfg_write(2, 0, 18'sd0);
    wait_valid(to);
    checks++; if (to || outch(0) != 3639) begin errors++; $display("FAIL cfg_ignored_writes: got %0d expected 3639 (timeout=%0b)", outch(0), to); end
    checks++; if (outch(2) != 0) begin errors++; $display("FAIL cfg_tick_write: got %0d expected 0", outch(2)); end
    set_in(16'sd0, 16'sd0, 16'sd0);
    wait_valid(to);
    checks++; if (to || outch(0) != 5661) begin errors++; $display("FAIL cfg_ch0_next: got %0d expected 5661 (timeout=%0b)", outch(0), to); end
    checks++; if (outch(2) != 3639) begin errors++; $display("FAIL cfg_ch2_next: got %0d expected 3639", outch(2)); end
  endtask

  task automatic test_reset_abort();
    bit to;
    int c, r;
    set_in(16'sd16384, 16'sd0, 16'sd0);
    do_reset();
    wait_valid(to);
    checks++; if (to || outch(0) != 3639) begin errors++; $display("FAIL abort_pre: got %0d expected 3639 (timeout=%0b)", outch(0), to); end
    wait_busy_rise(c, to);
    wait_until(c + 5);
    reset = 1'b0;
    #1;
    checks++; if (bus.out_bus !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_in_reset: got bus=%h valid=%b busy=%b expected all 0", bus.out_bus, bus.out_valid, bus.busy); end
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_held: got valid=%b busy=%b expected 0/0", bus.out_valid, bus.busy); end
    reset = 1'b1;
    r = cyc;
    wait_valid(to);
    checks++; if (to || (cyc - r) != 76) begin errors++; $display("FAIL abort_restart_latency: got %0d expected 76 (timeout=%0b)", cyc - r, to); end
    checks++; if (outch(0) != 3639) begin errors++; $display("FAIL abort_zero_history: got %0d expected 3639", outch(0)); end
  endtask

  task automatic test_dc();
    bit to;
    bit any_to = 1'b0;
    set_in(16'sd10000, 16'sd10000, 16'sd10000);
    do_reset();
    for (int t = 0; t < 200; t++) begin
      wait_valid(to);
      if (to) any_to = 1'b1;
    end
    checks++; if (any_to) begin errors++; $display("FAIL dc_timeout: got timeout expected 200 pulses"); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outch(k) < 9998 || outch(k) > 10002) begin errors++; $display("FAIL dc_ch%0d: got %0d expected 10000+-2", k, outch(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_impulse();
    test_saturation();
    test_shadow();
    test_cfg_edge();
    test_reset_abort();
    test_dc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
